// File: rtl/seg7_pkg.sv
// Seven-segment encodings shared by the scan display and its decoder.
// Bit order is {A,B,C,D,E,F,G,DP}, active-high.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'hfc;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hda;
  localparam logic [7:0] SEG_3     = 8'hf2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hb6;
  localparam logic [7:0] SEG_6     = 8'hbe;
  localparam logic [7:0] SEG_7     = 8'he0;
  localparam logic [7:0] SEG_8     = 8'hfe;
  localparam logic [7:0] SEG_9     = 8'hf6;
  localparam logic [7:0] SEG_A     = 8'hee;
  localparam logic [7:0] SEG_B     = 8'h3e;
  localparam logic [7:0] SEG_C     = 8'h9c;
  localparam logic [7:0] SEG_D     = 8'h7a;
  localparam logic [7:0] SEG_E     = 8'h9e;
  localparam logic [7:0] SEG_F     = 8'h8e;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         SEG_DP_BIT = 0;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to segment pattern. Outside hex mode the
// letters A-F show nothing rather than a misleading glyph.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  input  logic       hex_mode,
  output logic [7:0] seg
);

  // Table lookup; DP bit is always clear here and added by the caller.
  always_comb begin
    seg = SEG_BLANK;
    case (val)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'ha: seg = hex_mode ? SEG_A : SEG_BLANK;
      4'hb: seg = hex_mode ? SEG_B : SEG_BLANK;
      4'hc: seg = hex_mode ? SEG_C : SEG_BLANK;
      4'hd: seg = hex_mode ? SEG_D : SEG_BLANK;
      4'he: seg = hex_mode ? SEG_E : SEG_BLANK;
      4'hf: seg = hex_mode ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver. A pending frame buffer takes new data
// through valid/ready and is copied into the display buffer only on the
// last slot's tick, so a scan never mixes two frames.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV_CNT     = 50000,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hex_mode,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int DW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_CNT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [DW-1:0]            div;
  logic [IW-1:0]            idx;
  logic                     tick, wrap, accept;

  logic [DIGITS-1:0][3:0]   pend_data, disp_data;
  logic [DIGITS-1:0]        pend_dp, pend_blank, disp_dp, disp_blank;
  logic                     full;

  logic [DIGITS-1:0]        lz_blank;
  logic                     allz;
  logic [7:0]               dec_seg, seg_next;
  logic [DIGITS-1:0]        an_next;

  assign tick       = (div == DIV_MAX);
  assign wrap       = tick && (idx == IDX_MAX);
  assign load_ready = !full;
  assign accept     = load_valid && !full;

  // Slot divider: wraps every DIV_CNT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Digit index advances once per slot; frame_done marks the last slot's end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: accept into pending while empty, publish on frame wrap.
  // Accept and publish are exclusive because ready is low whenever full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      full       <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (accept) begin
      pend_data  <= load_data;
      pend_dp    <= load_dp;
      pend_blank <= load_blank;
      full       <= 1'b1;
    end else if (wrap && full) begin
      disp_data  <= pend_data;
      disp_dp    <= pend_dp;
      disp_blank <= pend_blank;
      full       <= 1'b0;
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and all higher digits are 0.
  always_comb begin
    lz_blank = '0;
    allz     = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      allz = 1'b1;
      for (int j = 0; j < DIGITS; j++)
        if (j >= i && disp_data[j] != 4'd0) allz = 1'b0;
      lz_blank[i] = allz;
    end
  end

  seg7_decoder u_dec (
    .val      (disp_data[idx]),
    .hex_mode (hex_mode),
    .seg      (dec_seg)
  );

  // Next segment/anode pattern for the current slot; blanking wins over DP.
  always_comb begin
    seg_next = dec_seg;
    seg_next[SEG_DP_BIT] = dec_seg[SEG_DP_BIT] | disp_dp[idx];
    if (disp_blank[idx] || (LZ_SUPPRESS != 0 && lz_blank[idx]))
      seg_next = SEG_BLANK;
    an_next = '0;
    an_next[idx] = 1'b1;
  end

  // Registered outputs, one cycle behind idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= '0;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench: main instance (DIV_CNT=4), a leading-zero instance and a
// DIV_CNT=1 instance share clock, reset and load payload; each has its own valid.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hex_mode = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0, load_blank = '0;

  logic        v_m = 1'b0, v_l = 1'b0, v_f = 1'b0;
  logic        rdy_m, rdy_l, rdy_f;
  logic [3:0]  an_m, an_l, an_f;
  logic [7:0]  seg_m, seg_l, seg_f;
  logic        fd_m, fd_l, fd_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(.DIGITS(4), .DIV_CNT(4), .LZ_SUPPRESS(0)) u_main (
    .clk(clk), .rst_n(rst_n), .hex_mode(hex_mode), .load_valid(v_m),
    .load_ready(rdy_m), .load_data(load_data), .load_dp(load_dp),
    .load_blank(load_blank), .an(an_m), .seg(seg_m), .frame_done(fd_m));

  seg7_scan_display #(.DIGITS(4), .DIV_CNT(4), .LZ_SUPPRESS(1)) u_lz (
    .clk(clk), .rst_n(rst_n), .hex_mode(hex_mode), .load_valid(v_l),
    .load_ready(rdy_l), .load_data(load_data), .load_dp(load_dp),
    .load_blank(load_blank), .an(an_l), .seg(seg_l), .frame_done(fd_l));

  seg7_scan_display #(.DIGITS(4), .DIV_CNT(1), .LZ_SUPPRESS(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .hex_mode(hex_mode), .load_valid(v_f),
    .load_ready(rdy_f), .load_data(load_data), .load_dp(load_dp),
    .load_blank(load_blank), .an(an_f), .seg(seg_f), .frame_done(fd_f));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the n-th following falling edge (outputs are stable there).
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset: N-index below counts falling edges after release.
    step(3);
    chk("rst_an",    {4'b0, an_m}, 8'h00);
    chk("rst_seg",   seg_m, 8'h00);
    chk("rst_fd",    {7'b0, fd_m}, 8'h00);
    chk("rst_ready", {7'b0, rdy_m}, 8'h01);
    rst_n = 1'b1;

    // Scan N1..N17: main holds each anode 4 cycles, frame_done at N16.
    for (int k = 1; k <= 17; k++) begin
      step(1);
      chk("scan_an",  {4'b0, an_m}, {4'b0, 4'b0001 << (((k - 1) / 4) % 4)});
      chk("scan_seg", seg_m, 8'hfc);
      chk("scan_fd",  {7'b0, fd_m}, (k == 16) ? 8'h01 : 8'h00);
      if (k <= 5) chk("fast_an", {4'b0, an_f}, {4'b0, 4'b0001 << ((k - 1) % 4)});
      if (k == 3) chk("fast_fd0", {7'b0, fd_f}, 8'h00);
      if (k == 4) chk("fast_fd1", {7'b0, fd_f}, 8'h01);
      if (k == 1) chk("lz_d0_zero", seg_l, 8'hfc);
      if (k == 5) chk("lz_d1_zero", seg_l, 8'h00);
    end

    // Load 1234 dp=0010 at N17; accepted at the next edge.
    load_data = 16'h1234; load_dp = 4'b0010; load_blank = 4'b0000; v_m = 1'b1;
    step(1);                                       // N18
    v_m = 1'b0;
    chk("ld_ready_low", {7'b0, rdy_m}, 8'h00);
    step(13);                                      // N31
    chk("ld_ready_hold", {7'b0, rdy_m}, 8'h00);
    step(1);                                       // N32
    chk("ld_ready_back", {7'b0, rdy_m}, 8'h01);
    chk("ld_old_d3", seg_m, 8'hfc);
    step(1);                                       // N33
    chk("ld_an0", {4'b0, an_m}, 8'h01);
    chk("ld_d0", seg_m, 8'h66);
    step(4);  chk("ld_d1", seg_m, 8'hf3);          // N37
    step(4);  chk("ld_d2", seg_m, 8'hda);          // N41
    step(4);  chk("ld_d3", seg_m, 8'h60);          // N45

    // Hex frame ABCD at N45; next wrap at edge 48.
    hex_mode = 1'b1; load_data = 16'habcd; load_dp = 4'b0000; v_m = 1'b1;
    step(1);  v_m = 1'b0;                          // N46
    step(3);  chk("hx_d0", seg_m, 8'h7a);          // N49
    step(4);  chk("hx_d1", seg_m, 8'h9c);          // N53
    step(4);  chk("hx_d2", seg_m, 8'h3e);          // N57
    step(4);  chk("hx_d3", seg_m, 8'hee);          // N61
    hex_mode = 1'b0;
    step(1);  chk("dec_d3", seg_m, 8'h00);         // N62
    step(3);  chk("dec_d0", seg_m, 8'h00);         // N65

    // Back-pressure: frame A (5678) then B (9012, dp 1001, blank 1000) held valid.
    load_data = 16'h5678; load_dp = 4'b0000; load_blank = 4'b0000; v_m = 1'b1;
    step(1);                                       // N66: A accepted
    load_data = 16'h9012; load_dp = 4'b1001; load_blank = 4'b1000;
    chk("bp_ready_low", {7'b0, rdy_m}, 8'h00);
    step(13); chk("bp_ready_hold", {7'b0, rdy_m}, 8'h00);   // N79
    step(1);  chk("bp_ready_up", {7'b0, rdy_m}, 8'h01);     // N80
    step(1);                                       // N81: B accepted
    v_m = 1'b0;
    chk("bp_ready_b", {7'b0, rdy_m}, 8'h00);
    chk("bpA_d0", seg_m, 8'hfe);
    step(4);  chk("bpA_d1", seg_m, 8'he0);         // N85
    step(4);  chk("bpA_d2", seg_m, 8'hbe);         // N89
    step(4);  chk("bpA_d3", seg_m, 8'hb6);         // N93
    step(4);  chk("bpB_d0", seg_m, 8'hdb);         // N97
    chk("bpB_ready", {7'b0, rdy_m}, 8'h01);
    step(4);  chk("bpB_d1", seg_m, 8'h60);         // N101
    step(4);  chk("bpB_d2", seg_m, 8'hfc);         // N105
    step(4);  chk("bpB_d3_blank", seg_m, 8'h00);   // N109

    // Leading-zero instance: 0050 with dp on the suppressed digit 2.
    load_data = 16'h0050; load_dp = 4'b0100; load_blank = 4'b0000; v_l = 1'b1;
    step(1);  v_l = 1'b0;                          // N110
    step(3);  chk("lz_d0", seg_l, 8'hfc);          // N113
    step(4);  chk("lz_d1", seg_l, 8'hb6);          // N117
    step(4);  chk("lz_d2", seg_l, 8'h00);          // N121
    step(4);  chk("lz_d3", seg_l, 8'h00);          // N125

    // Mid-frame reset on the fast instance with a frame pending.
    load_data = 16'h1234; load_dp = 4'b0000; v_f = 1'b1;
    step(1);                                       // N126
    v_f = 1'b0;
    chk("mr_pending", {7'b0, rdy_f}, 8'h00);
    rst_n = 1'b0;
    step(1);
    chk("mr_ready", {7'b0, rdy_f}, 8'h01);
    chk("mr_seg",   seg_f, 8'h00);
    chk("mr_an",    {4'b0, an_f}, 8'h00);
    chk("mr_main_an", {4'b0, an_m}, 8'h00);
    rst_n = 1'b1;
    step(1);  chk("mr_first", seg_f, 8'hfc);
    step(4);  chk("mr_discard", seg_f, 8'hfc);
    chk("mr_an_wrap", {4'b0, an_f}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
